// File: rtl/square_wave_analyzer_pkg.sv
// Shared types and constants for the square-wave analyzer: FSM states,
// default sizing and the control/status register map it feeds.
package square_wave_analyzer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SYNC      = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT    = 24;
  localparam int DEBOUNCE_DEFAULT = 4;

  // Register indices inside the CustomInstrument control/status block.
  localparam int REG_THR_HI     = 0;
  localparam int REG_THR_LO     = 1;
  localparam int REG_CTRL       = 2;
  localparam int REG_HIGH       = 3;
  localparam int REG_LOW        = 4;
  localparam int REG_PERIOD     = 5;
  localparam int REG_EDGE_COUNT = 6;
  localparam int REG_FLAGS      = 7;

  localparam int FLAG_TIMEOUT_BIT = 0;
  localparam int CTRL_ENABLE_BIT  = 0;
  localparam int CTRL_CLEAR_BIT   = 1;

endpackage

// File: rtl/square_wave_analyzer_hyst_debounce.sv
// Sample register, signed hysteresis comparator and debounce filter that turn
// the ADC stream into a clean level with same-cycle rise/fall strobes.
module square_wave_analyzer_hyst_debounce
  import square_wave_analyzer_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_sample,
  input  logic [15:0] i_thr_hi,
  input  logic [15:0] i_thr_lo,
  output logic        o_level,
  output logic        o_rise,
  output logic        o_fall
);

  localparam int RUN_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  logic [15:0]      r_sample;
  logic             r_raw;
  logic             r_level;
  logic [RUN_W-1:0] r_run;
  logic             w_accept;

  // Strobes fire in the cycle the new level is committed, so the consumer
  // sees the edge on the same clock that the level register flips.
  assign w_accept = (r_raw != r_level) && (r_run == RUN_LAST);
  assign o_level  = r_level;
  assign o_rise   = w_accept && r_raw;
  assign o_fall   = w_accept && !r_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample <= '0;
      r_raw    <= 1'b0;
      r_level  <= 1'b0;
      r_run    <= '0;
    end else begin
      r_sample <= i_sample;
      if ($signed(r_sample) >= $signed(i_thr_hi)) begin
        r_raw <= 1'b1;
      end else if ($signed(r_sample) <= $signed(i_thr_lo)) begin
        r_raw <= 1'b0;
      end
      if (w_accept) begin
        r_level <= r_raw;
        r_run   <= '0;
      end else if (r_raw != r_level) begin
        r_run <= r_run + RUN_ONE;
      end else begin
        r_run <= '0;
      end
    end
  end

endmodule

// File: rtl/square_wave_analyzer.sv
// Square-wave analyzer: measures high/low/period of the debounced level in
// clk cycles, counts rising edges and flags counter saturation.
module square_wave_analyzer
  import square_wave_analyzer_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [15:0]      i_sample_in,
  input  logic [15:0]      i_thr_hi,
  input  logic [15:0]      i_thr_lo,
  output logic             o_level,
  output logic             o_rise_pulse,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_high_cycles,
  output logic [CNT_W-1:0] o_low_cycles,
  output logic [CNT_W:0]   o_period_cycles,
  output logic [31:0]      o_edge_count,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W-1:0] r_high;
  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_count_edge;

  square_wave_analyzer_hyst_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_hyst_debounce (
    .clk      (clk),
    .reset    (reset),
    .i_sample (i_sample_in),
    .i_thr_hi (i_thr_hi),
    .i_thr_lo (i_thr_lo),
    .o_level  (w_level),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign o_level      = w_level;
  assign w_count_edge = w_rise && i_enable && (r_state != IDLE);

  // Rising edges are counted in every active state; a clear landing on the
  // same cycle as an edge leaves the count at one rather than zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_hcnt          <= '0;
      r_lcnt          <= '0;
      r_high          <= '0;
      o_rise_pulse    <= 1'b0;
      o_meas_valid    <= 1'b0;
      o_high_cycles   <= '0;
      o_low_cycles    <= '0;
      o_period_cycles <= '0;
      o_edge_count    <= '0;
      o_timeout       <= 1'b0;
    end else begin
      o_rise_pulse <= w_count_edge;
      o_meas_valid <= 1'b0;
      if (!i_enable) begin
        r_state <= IDLE;
        r_hcnt  <= '0;
        r_lcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: r_state <= SYNC;
          SYNC: begin
            if (w_rise) begin
              r_hcnt  <= CNT_ONE;
              r_state <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            if (w_fall) begin
              r_high  <= r_hcnt;
              r_hcnt  <= '0;
              r_lcnt  <= CNT_ONE;
              r_state <= MEAS_LOW;
            end else if (r_hcnt == CNT_MAX) begin
              o_timeout <= 1'b1;
              r_hcnt    <= '0;
              r_state   <= SYNC;
            end else begin
              r_hcnt <= r_hcnt + CNT_ONE;
            end
          end
          MEAS_LOW: begin
            if (w_rise) begin
              o_high_cycles   <= r_high;
              o_low_cycles    <= r_lcnt;
              o_period_cycles <= {1'b0, r_high} + {1'b0, r_lcnt};
              o_meas_valid    <= 1'b1;
              r_lcnt          <= '0;
              r_hcnt          <= CNT_ONE;
              r_state         <= MEAS_HIGH;
            end else if (r_lcnt == CNT_MAX) begin
              o_timeout <= 1'b1;
              r_lcnt    <= '0;
              r_state   <= SYNC;
            end else begin
              r_lcnt <= r_lcnt + CNT_ONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      if (i_clear) begin
        o_edge_count <= w_count_edge ? 32'd1 : 32'd0;
        o_timeout    <= 1'b0;
      end else if (w_count_edge) begin
        o_edge_count <= o_edge_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_square_wave_analyzer.sv
// Directed bench for square_wave_analyzer: a default-sized instance plus an
// 8-bit-counter instance for saturation, both fed from the same stimulus.
module tb_square_wave_analyzer;
  import square_wave_analyzer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] sample;
  logic [15:0] thrHi = 16'h4000;
  logic [15:0] thrLo = 16'h2000;

  logic        level, risePulse, measValid, timeout;
  logic [23:0] highCycles, lowCycles;
  logic [24:0] periodCycles;
  logic [31:0] edgeCount;

  logic        level8, risePulse8, measValid8, timeout8;
  logic [7:0]  highCycles8, lowCycles8;
  logic [8:0]  periodCycles8;
  logic [31:0] edgeCount8;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] highQ[$];
  logic [23:0] lowQ[$];
  logic [24:0] periodQ[$];
  int riseCount;
  int validCount8;

  square_wave_analyzer dut (
    .clk(clk), .reset(reset), .i_enable(enable), .i_clear(clear),
    .i_sample_in(sample), .i_thr_hi(thrHi), .i_thr_lo(thrLo),
    .o_level(level), .o_rise_pulse(risePulse), .o_meas_valid(measValid),
    .o_high_cycles(highCycles), .o_low_cycles(lowCycles),
    .o_period_cycles(periodCycles), .o_edge_count(edgeCount), .o_timeout(timeout)
  );

  square_wave_analyzer #(.CNT_W(8), .DEBOUNCE(4)) dut8 (
    .clk(clk), .reset(reset), .i_enable(enable), .i_clear(clear),
    .i_sample_in(sample), .i_thr_hi(thrHi), .i_thr_lo(thrLo),
    .o_level(level8), .o_rise_pulse(risePulse8), .o_meas_valid(measValid8),
    .o_high_cycles(highCycles8), .o_low_cycles(lowCycles8),
    .o_period_cycles(periodCycles8), .o_edge_count(edgeCount8), .o_timeout(timeout8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one sample value for a number of cycles and logs what the outputs did.
  task automatic runPhase(input logic [15:0] value, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      sample = value;
      tick();
      if (measValid) begin
        highQ.push_back(highCycles);
        lowQ.push_back(lowCycles);
        periodQ.push_back(periodCycles);
      end
      if (risePulse) riseCount++;
      if (measValid8) validCount8++;
    end
  endtask

  task automatic clearLog();
    highQ.delete();
    lowQ.delete();
    periodQ.delete();
    riseCount = 0;
    validCount8 = 0;
  endtask

  task automatic resetAll();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; sample = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    clearLog();
  endtask

  task automatic test_reset();
    resetAll();
    vectors++; if ({level, risePulse, measValid, timeout} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000", {level, risePulse, measValid, timeout}); end
    vectors++; if (highCycles !== 24'd0 || lowCycles !== 24'd0) begin miscompares++; $display("[TB] FAIL reset_durations: got %0d/%0d expected 0/0", highCycles, lowCycles); end
    vectors++; if (periodCycles !== 25'd0) begin miscompares++; $display("[TB] FAIL reset_period: got %0d expected 0", periodCycles); end
    vectors++; if (edgeCount !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_edge_count: got %0d expected 0", edgeCount); end
  endtask

  task automatic test_periodic();
    enable = 1'b1;
    for (int p = 0; p < 3; p++) begin
      runPhase(16'h0000, 2096);
      runPhase(16'h7FFF, 2093);
    end
    runPhase(16'h0000, 10);
    vectors++; if (highQ.size() !== 2) begin miscompares++; $display("[TB] FAIL periodic_valid_count: got %0d expected 2", highQ.size()); end
    foreach (highQ[i]) begin
      vectors++; if (highQ[i] !== 24'd2093) begin miscompares++; $display("[TB] FAIL periodic_high[%0d]: got %0d expected 2093", i, highQ[i]); end
      vectors++; if (lowQ[i] !== 24'd2096) begin miscompares++; $display("[TB] FAIL periodic_low[%0d]: got %0d expected 2096", i, lowQ[i]); end
      vectors++; if (periodQ[i] !== 25'd4189) begin miscompares++; $display("[TB] FAIL periodic_period[%0d]: got %0d expected 4189", i, periodQ[i]); end
    end
    vectors++; if (riseCount !== 3) begin miscompares++; $display("[TB] FAIL periodic_rise_pulses: got %0d expected 3", riseCount); end
    vectors++; if (edgeCount !== 32'd3) begin miscompares++; $display("[TB] FAIL periodic_edge_count: got %0d expected 3", edgeCount); end
    vectors++; if (level !== 1'b0) begin miscompares++; $display("[TB] FAIL periodic_final_level: got %0d expected 0", level); end
  endtask

  // Continues from the low tail of the periodic run: 10 low cycles already seen.
  task automatic test_glitch();
    clearLog();
    runPhase(16'h0000, 20);
    runPhase(16'h7FFF, 3);
    runPhase(16'h0000, 20);
    vectors++; if (riseCount !== 0) begin miscompares++; $display("[TB] FAIL glitch3_rise: got %0d expected 0", riseCount); end
    vectors++; if (highQ.size() !== 0) begin miscompares++; $display("[TB] FAIL glitch3_valid: got %0d expected 0", highQ.size()); end
    vectors++; if (highCycles !== 24'd2093 || lowCycles !== 24'd2096) begin miscompares++; $display("[TB] FAIL glitch3_held: got %0d/%0d expected 2093/2096", highCycles, lowCycles); end
    runPhase(16'h7FFF, 4);
    runPhase(16'h0000, 20);
    vectors++; if (riseCount !== 1) begin miscompares++; $display("[TB] FAIL glitch4_rise: got %0d expected 1", riseCount); end
    vectors++; if (highQ.size() !== 1) begin miscompares++; $display("[TB] FAIL glitch4_valid: got %0d expected 1", highQ.size()); end
    else begin
      vectors++; if (lowQ[0] !== 24'd53 || highQ[0] !== 24'd2093 || periodQ[0] !== 25'd2146) begin miscompares++; $display("[TB] FAIL glitch4_meas: got %0d/%0d/%0d expected 2093/53/2146", highQ[0], lowQ[0], periodQ[0]); end
    end
  endtask

  task automatic test_hysteresis();
    int n;
    int badLevel;
    logic sawValid;
    n = 0; sawValid = 1'b0;
    sample = 16'h4000;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (risePulse) begin
        sawValid = measValid;
        break;
      end
    end
    vectors++; if (n !== 6) begin miscompares++; $display("[TB] FAIL hyst_rise_latency: got %0d expected 6", n); end
    vectors++; if (sawValid !== 1'b1 || highCycles !== 24'd4 || lowCycles !== 24'd20 || periodCycles !== 25'd24) begin miscompares++; $display("[TB] FAIL hyst_short_meas: got v%0d %0d/%0d/%0d expected v1 4/20/24", sawValid, highCycles, lowCycles, periodCycles); end
    runPhase(16'h4000, 14);
    badLevel = 0;
    for (int i = 0; i < 40; i++) begin
      sample = i[0] ? 16'h3800 : 16'h2800;
      tick();
      if (level !== 1'b1) badLevel++;
    end
    vectors++; if (badLevel !== 0) begin miscompares++; $display("[TB] FAIL hyst_hold_high: got %0d low cycles expected 0", badLevel); end
    n = 0;
    sample = 16'h2000;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (level === 1'b0) break;
    end
    vectors++; if (n !== 6) begin miscompares++; $display("[TB] FAIL hyst_fall_latency: got %0d expected 6", n); end
    runPhase(16'h0000, 10);
  endtask

  task automatic test_timeout();
    int n;
    resetAll();
    enable = 1'b1;
    runPhase(16'h0000, 10);
    n = 0;
    sample = 16'h7FFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (risePulse8) break;
    end
    vectors++; if (n !== 6 || level8 !== 1'b1) begin miscompares++; $display("[TB] FAIL to_first_rise: got %0d cycles level %0d expected 6 level 1", n, level8); end
    runPhase(16'h7FFF, 254);
    vectors++; if (timeout8 !== 1'b0) begin miscompares++; $display("[TB] FAIL to_early: got %0d expected 0", timeout8); end
    runPhase(16'h7FFF, 1);
    vectors++; if (timeout8 !== 1'b1) begin miscompares++; $display("[TB] FAIL to_set: got %0d expected 1", timeout8); end
    vectors++; if (dut8.r_state !== SYNC) begin miscompares++; $display("[TB] FAIL to_state: got %0d expected %0d", dut8.r_state, SYNC); end
    runPhase(16'h7FFF, 20);
    vectors++; if (validCount8 !== 0 || {highCycles8, lowCycles8, periodCycles8} !== 25'd0) begin miscompares++; $display("[TB] FAIL to_no_meas: got %0d pulses %0d/%0d/%0d expected 0 0/0/0", validCount8, highCycles8, lowCycles8, periodCycles8); end
    vectors++; if (edgeCount8 !== 32'd1) begin miscompares++; $display("[TB] FAIL to_edge_count: got %0d expected 1", edgeCount8); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (timeout8 !== 1'b0 || edgeCount8 !== 32'd0) begin miscompares++; $display("[TB] FAIL to_clear: got %0d/%0d expected 0/0", timeout8, edgeCount8); end
    runPhase(16'h0000, 10);
    runPhase(16'h7FFF, 5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if (edgeCount8 !== 32'd1 || risePulse8 !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_with_edge: got %0d pulse %0d expected 1 pulse 1", edgeCount8, risePulse8); end
  endtask

  task automatic test_enable_drop();
    resetAll();
    enable = 1'b1;
    runPhase(16'h0000, 30);
    runPhase(16'h7FFF, 20);
    runPhase(16'h0000, 30);
    runPhase(16'h7FFF, 20);
    runPhase(16'h0000, 15);
    vectors++; if (highQ.size() !== 1 || highCycles !== 24'd20 || lowCycles !== 24'd30) begin miscompares++; $display("[TB] FAIL en_before: got n%0d %0d/%0d expected n1 20/30", highQ.size(), highCycles, lowCycles); end
    clearLog();
    enable = 1'b0;
    runPhase(16'h0000, 5);
    vectors++; if (highQ.size() !== 0 || edgeCount !== 32'd2 || highCycles !== 24'd20 || lowCycles !== 24'd30) begin miscompares++; $display("[TB] FAIL en_idle_hold: got n%0d e%0d %0d/%0d expected n0 e2 20/30", highQ.size(), edgeCount, highCycles, lowCycles); end
    enable = 1'b1;
    runPhase(16'h0000, 15);
    runPhase(16'h7FFF, 25);
    runPhase(16'h0000, 35);
    vectors++; if (highQ.size() !== 0 || edgeCount !== 32'd3) begin miscompares++; $display("[TB] FAIL en_first_rise: got n%0d e%0d expected n0 e3", highQ.size(), edgeCount); end
    runPhase(16'h7FFF, 25);
    runPhase(16'h0000, 10);
    vectors++; if (highQ.size() !== 1 || edgeCount !== 32'd4) begin miscompares++; $display("[TB] FAIL en_second_rise: got n%0d e%0d expected n1 e4", highQ.size(), edgeCount); end
    else begin
      vectors++; if (highQ[0] !== 24'd25 || lowQ[0] !== 24'd35 || periodQ[0] !== 25'd60) begin miscompares++; $display("[TB] FAIL en_meas: got %0d/%0d/%0d expected 25/35/60", highQ[0], lowQ[0], periodQ[0]); end
    end
  endtask

  task automatic test_reset_mid();
    resetAll();
    enable = 1'b1;
    runPhase(16'h0000, 2096);
    runPhase(16'h7FFF, 2093);
    runPhase(16'h0000, 2096);
    runPhase(16'h7FFF, 10);
    vectors++; if (dut.r_state !== MEAS_HIGH || highQ.size() !== 1) begin miscompares++; $display("[TB] FAIL rm_pre_state: got %0d n%0d expected %0d n1", dut.r_state, highQ.size(), MEAS_HIGH); end
    reset = 1'b1;
    sample = 16'h0000;
    tick();
    vectors++; if ({level, risePulse, measValid, timeout} !== 4'b0000 || edgeCount !== 32'd0) begin miscompares++; $display("[TB] FAIL rm_flags: got %b e%0d expected 0000 e0", {level, risePulse, measValid, timeout}, edgeCount); end
    vectors++; if (highCycles !== 24'd0 || lowCycles !== 24'd0 || periodCycles !== 25'd0) begin miscompares++; $display("[TB] FAIL rm_results: got %0d/%0d/%0d expected 0/0/0", highCycles, lowCycles, periodCycles); end
    vectors++; if (dut.r_state !== IDLE) begin miscompares++; $display("[TB] FAIL rm_state: got %0d expected %0d", dut.r_state, IDLE); end
    reset = 1'b0;
    clearLog();
    runPhase(16'h0000, 2096);
    runPhase(16'h7FFF, 2093);
    runPhase(16'h0000, 2096);
    runPhase(16'h7FFF, 10);
    vectors++; if (highQ.size() !== 1 || edgeCount !== 32'd2) begin miscompares++; $display("[TB] FAIL rm_after_count: got n%0d e%0d expected n1 e2", highQ.size(), edgeCount); end
    else begin
      vectors++; if (highQ[0] !== 24'd2093 || lowQ[0] !== 24'd2096 || periodQ[0] !== 25'd4189) begin miscompares++; $display("[TB] FAIL rm_after_meas: got %0d/%0d/%0d expected 2093/2096/4189", highQ[0], lowQ[0], periodQ[0]); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; sample = 16'h0000;
    test_reset();
    test_periodic();
    test_glitch();
    test_hysteresis();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/square_wave_analyzer.md
Name: square_wave_analyzer

Overview:
- Downstream consumer of the 16-bit square-wave/bitstream channel driven on an instrument output and looped back into an ADC input (inputa..inputd).
- Converts the signed sample stream to a clean logic level using a hysteresis comparator and a debounce filter.
- Measures high time, low time and period in clk cycles, and counts rising edges.
- Results feed the CustomInstrument status registers; thresholds come from control registers.

Parameters:
- CNT_W, 24, width of high/low duration counters (period is CNT_W+1).
- DEBOUNCE, 4, consecutive cycles a new comparator level must persist before it is accepted (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  measurement enable; low forces IDLE
- clear  in  1  one-cycle pulse; zeroes edge_count and sticky flags
- sample_in  in  16  signed ADC sample
- thr_hi  in  16  signed rising threshold
- thr_lo  in  16  signed falling threshold (thr_lo <= thr_hi required)
- level  out  1  debounced logic level
- rise_pulse  out  1  one-cycle pulse on each accepted rising edge
- meas_valid  out  1  one-cycle pulse when the high/low/period outputs update
- high_cycles  out  CNT_W  last complete high duration
- low_cycles  out  CNT_W  last complete low duration
- period_cycles  out  CNT_W+1  high_cycles + low_cycles
- edge_count  out  32  accepted rising edges, wraps modulo 2^32
- timeout  out  1  sticky; a duration counter saturated

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0; raw comparator level 0.
- Stage 1 registers sample_in.
- Stage 2 comparator, signed compare:
  - raw becomes 1 when sample >= thr_hi.
  - raw becomes 0 when sample <= thr_lo.
  - Otherwise raw holds.
  - If thr_lo > thr_hi, the thr_hi test takes priority.
- Debounce:
  - level changes only after raw differs from level for DEBOUNCE consecutive cycles.
  - Any reversion of raw restarts the run count.
- Latency: input crossing to level change and rise_pulse is DEBOUNCE+2 cycles. Both edges see the same delay, so measured durations are exact.
- FSM states:
  - IDLE: entered on reset or when enable=0. Counters are held at 0 and outputs hold their last values. Goes to SYNC when enable=1.
  - SYNC: waits for the first accepted rising edge, which increments edge_count and pulses rise_pulse. Goes to MEAS_HIGH with hcnt=1. A partial first pulse is never reported.
  - MEAS_HIGH: hcnt increments each cycle. On a falling edge, latch hcnt to an internal high register, set lcnt=1, go to MEAS_LOW.
  - MEAS_LOW: lcnt increments each cycle. On a rising edge, in the same cycle:
    - high_cycles <= latched high
    - low_cycles <= lcnt
    - period_cycles <= their zero-extended sum
    - meas_valid pulses; rise_pulse pulses; edge_count increments
    - hcnt=1; go to MEAS_HIGH
- Saturation: if hcnt or lcnt reaches all-ones, set timeout and go to SYNC with no output update. The level is stuck, or the period is too long to measure.
- rise_pulse and edge_count operate in every state except IDLE.
- clear:
  - Zeroes edge_count and timeout; the FSM is unaffected.
  - If clear coincides with an edge increment, the result is 1.
- enable falling mid-measurement: go to IDLE next cycle and discard partial counts.
- Reset mid-operation: all state returns to reset values in the next cycle.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, SYNC, MEAS_HIGH, MEAS_LOW).
  - Default CNT_W and DEBOUNCE constants.
  - Control/status register index constants for thresholds, results and flags.
- One sub-module, hyst_debounce: stages 1–2 plus the debounce filter. It outputs level and single-cycle rise/fall strobes.
- The FSM and counters live in the top module.

Test Plan:
- Periodic square input: 2096 cycles of 0x0000 then 2093 cycles of 0x7FFF, thr_hi=0x4000, thr_lo=0x2000, enable=1.
  - First meas_valid occurs at the second accepted rising edge.
  - high_cycles=2093, low_cycles=2096, period_cycles=4189; repeats each period.
  - edge_count increments once per period.
- Glitch rejection: DEBOUNCE=4, a 3-cycle 0x7FFF spike inside a low phase → no rise_pulse, measurements unchanged. A 4-cycle spike → accepted.
- Hysteresis: sample oscillating 0x2800↔0x3800 after level=1 → level stays 1. A drop to 0x2000 → falling edge after DEBOUNCE+2 cycles.
- Timeout: CNT_W=8, constant 0x7FFF after the first rising edge → timeout=1 after 255 high cycles, state SYNC, meas_valid never pulses. A clear pulse → timeout=0, edge_count=0.
- enable dropped mid-MEAS_LOW, then reasserted → no meas_valid until two full rising edges after re-enable; prior results held.
- Reset asserted during MEAS_HIGH → next cycle all outputs 0, state IDLE. The first measurement after release matches the periodic-square-input case.
